spike_event_fifo: RTL and testbench

Downstream consumer of `izhikevich_core`. Turns the core's per-step `is_spiking` flag into timestamped spike events and buffers them in a FIFO. Events are drained by a host or router over a valid/ready handshake. Owns the simulation step counter, so every event carries the index of the integration step that produced it.

---
 rtl/spike_event_fifo.sv | 72 +++++++
 tb/tb_spike_event_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: stamps each spiking integration step with its step index and buffers
// the events in a show-ahead FIFO drained over valid/ready.
module spike_event_fifo #(
    parameter int TW = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          apply,
    input  logic          is_spiking,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [TW-1:0] ev_time,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [15:0]   overflow_cnt
);
    logic [TW-1:0] mem [DEPTH];
    logic [TW-1:0] step_cnt, stamp;
    logic          apply_d;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_req, push, pop;

    assign empty    = count == '0;
    assign full     = count == (AW+1)'(DEPTH);
    assign ev_valid = !empty;
    assign ev_time  = empty ? '0 : mem[rd_ptr];
    assign pop      = ev_valid && ev_ready;
    // the core's is_spiking is only meaningful the cycle after its apply
    assign push_req = apply_d && is_spiking;
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt     <= '0;
            stamp        <= '0;
            apply_d      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else if (clear) begin
            step_cnt     <= '0;
            stamp        <= '0;
            apply_d      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else begin
            apply_d <= apply;
            if (apply) begin
                stamp    <= step_cnt;
                step_cnt <= step_cnt + TW'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push_req && !push && overflow_cnt != 16'hFFFF)
                overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk)
        if (push && !clear)
            mem[wr_ptr] <= stamp;
endmodule

// File: tb/tb_spike_event_fifo.sv
// tb_spike_event_fifo: scoreboard bench for spike_event_fifo (TW=16 main instance, TW=4 wrap instance).
module tb_spike_event_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst = 1'b1, clear = 1'b0, apply = 1'b0, is_spiking = 1'b0, ev_ready = 1'b0;
    logic        ev_valid, full, empty;
    logic [15:0] ev_time, overflow_cnt;
    logic [4:0]  count;
    logic        w_valid, w_full, w_empty;
    logic [3:0]  w_time;
    logic [4:0]  w_count;
    logic [15:0] w_ovf;

    int          n_chk = 0, n_fail = 0, w_seen = 0;
    logic [15:0] q[$];
    logic [3:0]  wq[$];
    logic [15:0] m_step, m_stamp, m_ovf;
    logic        m_apply_d;

    spike_event_fifo #(.TW(16), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .apply(apply), .is_spiking(is_spiking),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_time(ev_time), .count(count),
        .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
    );

    spike_event_fifo #(.TW(4), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(rst), .clear(clear), .apply(apply), .is_spiking(is_spiking),
        .ev_valid(w_valid), .ev_ready(1'b1), .ev_time(w_time), .count(w_count),
        .full(w_full), .empty(w_empty), .overflow_cnt(w_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_step = '0;
        m_stamp = '0;
        m_ovf = '0;
        m_apply_d = 1'b0;
        q.delete();
        wq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // one clock: drive inputs, check the head against the scoreboard, advance the model, check state
    task automatic tick(input logic a, input logic s, input logic r, input logic c);
        apply = a;
        is_spiking = s;
        ev_ready = r;
        clear = c;
        @(negedge clk);
        check("valid", ev_valid, q.size() != 0);
        if (q.size() != 0)
            check("head", ev_time, q[0]);
        if (w_valid) begin
            w_seen++;
            if (wq.size() != 0)
                check("wrap", w_time, wq.pop_front());
            else
                check("wrap_extra", w_valid, 1'b0);
        end
        if (c)
            model_reset();
        else begin
            if (r && q.size() != 0)
                void'(q.pop_front());
            if (m_apply_d && s) begin
                wq.push_back(m_stamp[3:0]);
                if (q.size() < DEPTH)
                    q.push_back(m_stamp);
                else if (m_ovf != 16'hFFFF)
                    m_ovf++;
            end
            if (a) begin
                m_stamp = m_step;
                m_step++;
            end
            m_apply_d = a;
        end
        @(posedge clk);
        #1;
        check("count", count, q.size());
        check("full", full, q.size() == DEPTH);
        check("empty", empty, q.size() == 0);
        check("ovf", overflow_cnt, m_ovf);
    endtask

    task automatic spike_step(input logic r);
        tick(1'b1, 1'b0, r, 1'b0);
        tick(1'b0, 1'b1, r, 1'b0);
    endtask

    initial begin
        do_reset();
        check("rst_valid", ev_valid, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_time", ev_time, 16'h0);

        // single spike on the third step
        tick(1, 0, 0, 0); tick(0, 0, 0, 0);
        tick(1, 0, 0, 0); tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("single_early", ev_valid, 1'b0);
        tick(0, 1, 0, 0);
        check("single_valid", ev_valid, 1'b1);
        check("single_time", ev_time, 16'd2);
        check("single_count", count, 5'd1);
        repeat (3) tick(0, 1, 0, 0);
        check("held_spike", count, 5'd1);

        // fill, overflow, pass-through at full, stall, drain
        do_reset();
        repeat (DEPTH) spike_step(1'b0);
        check("fill_full", full, 1'b1);
        check("fill_count", count, 5'd16);
        repeat (3) spike_step(1'b0);
        check("ovf3", overflow_cnt, 16'd3);
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0);
        check("pt_count", count, 5'd16);
        check("pt_ovf", overflow_cnt, 16'd3);
        repeat (5) tick(0, 0, 0, 0);
        repeat (DEPTH) tick(0, 0, 1, 0);
        check("drained", empty, 1'b1);

        // async reset mid-cycle with five entries queued and a nonzero drop count
        repeat (5) spike_step(1'b0);
        check("pre_rst_count", count, 5'd5);
        #1 rst = 1'b1;
        #1;
        check("arst_empty", empty, 1'b1);
        check("arst_ovf", overflow_cnt, 16'd0);
        check("arst_count", count, 5'd0);
        check("arst_time", ev_time, 16'd0);
        model_reset();
        #1 rst = 1'b0;

        // back-to-back steps through the wrapping 4-bit stamp instance
        w_seen = 0;
        repeat (17) tick(1, 1, 1, 0);
        tick(0, 1, 1, 0);
        repeat (3) tick(0, 0, 1, 0);
        check("wrap_n", w_seen, 17);
        check("wrap_empty", w_empty, 1'b1);
        check("wrap_cnt", w_count, 5'd0);
        check("wrap_full", w_full, 1'b0);
        check("wrap_ovf", w_ovf, 16'd0);

        // clear on the same cycle as a push
        spike_step(1'b0);
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 1);
        check("clr_empty", empty, 1'b1);
        check("clr_count", count, 5'd0);
        spike_step(1'b0);
        check("clr_restamp", ev_time, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
